conv3x3_stream_filter: RTL

Parametrised streaming 3x3 neighbourhood filter for the camera-to-VGA pixel path, running in the `clk` domain between the frame buffer read-out and the display formatter. It accepts one raster-order pixel per `in_valid` cycle. It keeps two line buffers and produces one filtered pixel per window. The selectable kernels are bypass, Gaussian, sharpen and Laplacian edge. Image size, channel count and channel depth are generic, and out-of-image neighbours are zero-padded by position masks.

---
 rtl/conv3x3_stream_filter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/conv3x3_stream_filter.sv
// conv3x3_stream_filter: raster-order 3x3 neighbourhood filter with two line
// buffers, position-mask zero padding and a two-register output pipeline
// (taps/sum, then clamp). Kernels: bypass, Gaussian, sharpen, Laplacian.
module conv3x3_stream_filter #(
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int CH_BITS  = 4,
  parameter int CHANNELS = 3,
  parameter int PIX_W    = CHANNELS * CH_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic [PIX_W-1:0] out_pixel,
  output logic             frame_err
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int IW = CH_BITS + 4;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [IW-1:0] MAX_V  = IW'((1 << CH_BITS) - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
  state_t state_reg, state_next;

  logic [XW-1:0] x_reg, pos_x, cx_reg;
  logic [YW-1:0] y_reg, pos_y, cy_reg;
  logic [1:0]    mode_reg;
  logic [PIX_W-1:0] lb0 [IMG_W];   // previous line
  logic [PIX_W-1:0] lb1 [IMG_W];   // line before that
  logic [PIX_W-1:0] win_reg [3][3];
  logic [PIX_W-1:0] win_next [3][3];
  logic [PIX_W-1:0] tap [3][3];
  logic sof_in, accept, flush_gen, emit, shift;
  logic mask_top, mask_bot, mask_left, mask_right;
  logic [CHANNELS-1:0][IW-1:0] s1_val_next, s1_val_reg;
  logic s1_valid_reg, s1_sof_reg, s1_eof_reg, s1_abs_reg;
  logic [PIX_W-1:0] clamp_pix;

  // An SOF always restarts the frame at (0,0); FLUSH windows use an all-zero bottom row.
  assign sof_in    = in_valid & in_sof;
  assign accept    = sof_in | (in_valid & ((state_reg == FILL) | (state_reg == RUN)));
  assign flush_gen = (state_reg == FLUSH) & ~sof_in;
  assign emit      = flush_gen | ((state_reg == RUN) & in_valid & ~in_sof);
  assign shift     = accept | flush_gen;
  assign pos_x     = sof_in ? '0 : x_reg;
  assign pos_y     = sof_in ? '0 : y_reg;
  assign mask_top   = (cy_reg == '0);
  assign mask_bot   = (cy_reg == Y_LAST);
  assign mask_left  = (cx_reg == '0);
  assign mask_right = (cx_reg == X_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (sof_in) begin
      state_next = FILL;
    end else begin
      case (state_reg)
        FILL:    if (in_valid && x_reg == '0 && y_reg == YW'(1)) state_next = RUN;
        RUN:     if (in_valid && x_reg == X_LAST && y_reg == Y_LAST) state_next = FLUSH;
        FLUSH:   if (cx_reg == X_LAST && cy_reg == Y_LAST) state_next = IDLE;
        default: state_next = state_reg;
      endcase
    end
  end

  // Input position, window-centre position and per-frame kernel latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg <= '0; y_reg <= '0; cx_reg <= '0; cy_reg <= '0; mode_reg <= '0;
    end else begin
      if (accept) begin
        x_reg <= (pos_x == X_LAST) ? '0 : pos_x + 1'b1;
        if (pos_x == X_LAST) y_reg <= (pos_y == Y_LAST) ? '0 : pos_y + 1'b1;
        else                 y_reg <= pos_y;
      end else if (flush_gen) begin
        x_reg <= (x_reg == X_LAST) ? '0 : x_reg + 1'b1;
      end
      if (sof_in) begin
        cx_reg <= '0; cy_reg <= '0; mode_reg <= mode;
      end else if (emit) begin
        cx_reg <= (cx_reg == X_LAST) ? '0 : cx_reg + 1'b1;
        if (cx_reg == X_LAST) cy_reg <= (cy_reg == Y_LAST) ? '0 : cy_reg + 1'b1;
      end
    end
  end

  // Line buffers: push the column down one line on every accepted pixel
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[pos_x] <= in_pixel;
      lb1[pos_x] <= lb0[pos_x];
    end
  end

  // Window after this cycle's shift, and its zero-padded taps
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_next[r][0] = win_reg[r][1];
      win_next[r][1] = win_reg[r][2];
    end
    win_next[0][2] = lb1[pos_x];
    win_next[1][2] = lb0[pos_x];
    win_next[2][2] = flush_gen ? '0 : in_pixel;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        tap[r][c] = ((r == 0 && mask_top) || (r == 2 && mask_bot) ||
                     (c == 0 && mask_left) || (c == 2 && mask_right)) ? '0 : win_next[r][c];
      end
    end
  end

  // 3x3 window shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win_reg[r][c] <= '0;
    end else if (shift) begin
      win_reg <= win_next;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    localparam int HI = PIX_W - 1 - gi * CH_BITS;
    logic [IW-1:0] c, n, s, e, w, nw, ne, sw, se, ring, diag, gauss, v, mag;
    logic [CH_BITS-1:0] sat;
    assign nw = IW'(tap[0][0][HI -: CH_BITS]);
    assign n  = IW'(tap[0][1][HI -: CH_BITS]);
    assign ne = IW'(tap[0][2][HI -: CH_BITS]);
    assign w  = IW'(tap[1][0][HI -: CH_BITS]);
    assign c  = IW'(tap[1][1][HI -: CH_BITS]);
    assign e  = IW'(tap[1][2][HI -: CH_BITS]);
    assign sw = IW'(tap[2][0][HI -: CH_BITS]);
    assign s  = IW'(tap[2][1][HI -: CH_BITS]);
    assign se = IW'(tap[2][2][HI -: CH_BITS]);
    assign ring  = n + s + e + w;
    assign diag  = nw + ne + sw + se;
    assign gauss = diag + (ring << 1) + (c << 2);
    // Sharpen/Laplacian wrap modulo 2^IW; the MSB is the sign for the clamp stage.
    assign s1_val_next[gi] = (mode_reg == 2'd0) ? c :
                             (mode_reg == 2'd1) ? (gauss >> 4) :
                             (mode_reg == 2'd2) ? ((c << 2) + c - ring) :
                                                  ((c << 2) - ring);
    assign v   = s1_val_reg[gi];
    assign mag = (s1_abs_reg && v[IW-1]) ? (~v + 1'b1) : v;
    assign sat = (!s1_abs_reg && v[IW-1]) ? '0 :
                 (mag > MAX_V) ? {CH_BITS{1'b1}} : mag[CH_BITS-1:0];
    assign clamp_pix[HI -: CH_BITS] = sat;
  end

  // Stage 1: tap sums plus frame markers for the emitted window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0; s1_sof_reg <= 1'b0; s1_eof_reg <= 1'b0;
      s1_abs_reg <= 1'b0; s1_val_reg <= '0;
    end else begin
      s1_valid_reg <= emit;
      s1_sof_reg   <= emit && cx_reg == '0 && cy_reg == '0;
      s1_eof_reg   <= emit && cx_reg == X_LAST && cy_reg == Y_LAST;
      s1_abs_reg   <= (mode_reg == 2'd3);
      s1_val_reg   <= s1_val_next;
    end
  end

  // Stage 2: clamp and present; an aborting SOF drops the in-flight result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0; out_sof <= 1'b0; out_eof <= 1'b0;
      out_pixel <= '0; frame_err <= 1'b0;
    end else begin
      frame_err <= sof_in && (state_reg != IDLE);
      if (sof_in && state_reg != IDLE) begin
        out_valid <= 1'b0; out_sof <= 1'b0; out_eof <= 1'b0; out_pixel <= '0;
      end else begin
        out_valid <= s1_valid_reg;
        out_sof   <= s1_valid_reg & s1_sof_reg;
        out_eof   <= s1_valid_reg & s1_eof_reg;
        out_pixel <= s1_valid_reg ? clamp_pix : '0;
      end
    end
  end
endmodule
